// File: rtl/riscv_em_ppreg_pkg.sv
// Shared definitions for the execute/memory pipeline register:
// store-size encodings, mcause codes, the stage record and exception encoding.
package riscv_em_ppreg_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [3:0] CAUSE_INST_MISALIGN  = 4'd0;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
  } exc_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] result;
    logic [63:0] dcache_addr;
    logic [63:0] csrwritedata;
    logic [63:0] wdata;
    logic [7:0]  byte_en;
    logic        memw;
    logic        memr;
    logic        regw;
    logic [2:0]  memext;
    logic [4:0]  rdaddr;
    logic [2:0]  resultsrc;
    logic        exc_valid;
    logic [3:0]  exc_cause;
  } em_reg_t;

  // Instruction misalignment outranks load, which outranks store.
  function automatic exc_t exc_encode(input logic inst_mis, input logic load_mis,
                                      input logic store_mis);
    exc_t e;
    e.valid = inst_mis | load_mis | store_mis;
    if (inst_mis) begin
      e.cause = CAUSE_INST_MISALIGN;
    end else if (load_mis) begin
      e.cause = CAUSE_LOAD_MISALIGN;
    end else if (store_mis) begin
      e.cause = CAUSE_STORE_MISALIGN;
    end else begin
      e.cause = 4'd0;
    end
    return e;
  endfunction

endpackage

// File: rtl/riscv_em_ppreg_store_align.sv
// Store lane alignment: replicates store data across the 64-bit bus and
// produces the byte strobes for the addressed lanes.
module riscv_store_align
  import riscv_em_ppreg_pkg::*;
(
  input  logic [2:0]  addr_i,
  input  logic [1:0]  storesrc_i,
  input  logic [63:0] data_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  byte_en_o
);

  // Replicate the sized operand and shift the strobe to its naturally aligned lane.
  always_comb begin
    wdata_o   = 64'd0;
    byte_en_o = 8'h00;
    case (storesrc_i)
      SZ_B: begin
        wdata_o   = {8{data_i[7:0]}};
        byte_en_o = 8'h01 << addr_i;
      end
      SZ_H: begin
        wdata_o   = {4{data_i[15:0]}};
        byte_en_o = 8'h03 << {addr_i[2:1], 1'b0};
      end
      SZ_W: begin
        wdata_o   = {2{data_i[31:0]}};
        byte_en_o = 8'h0F << {addr_i[2], 2'b00};
      end
      SZ_D: begin
        wdata_o   = data_i;
        byte_en_o = 8'hFF;
      end
      default: begin
        wdata_o   = 64'd0;
        byte_en_o = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/riscv_em_ppreg.sv
// Execute-to-memory pipeline register with store alignment, misalignment
// exception qualification, stall-hold and (deferred) flush-to-bubble.
module riscv_em_ppreg
  import riscv_em_ppreg_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_riscv_em_clk,
  input  logic            i_riscv_em_rst,
  input  logic            i_riscv_em_globstall,
  input  logic            i_riscv_em_flush,
  input  logic            i_riscv_em_valid,
  input  logic [XLEN-1:0] i_riscv_em_pc,
  input  logic [XLEN-1:0] i_riscv_em_result,
  input  logic [XLEN-1:0] i_riscv_em_dcache_addr,
  input  logic [XLEN-1:0] i_riscv_em_store_data,
  input  logic            i_riscv_em_memw,
  input  logic            i_riscv_em_memr,
  input  logic [1:0]      i_riscv_em_storesrc,
  input  logic [2:0]      i_riscv_em_memext,
  input  logic            i_riscv_em_regw,
  input  logic [4:0]      i_riscv_em_rdaddr,
  input  logic [2:0]      i_riscv_em_resultsrc,
  input  logic [XLEN-1:0] i_riscv_em_csrwritedata,
  input  logic            i_riscv_em_inst_misaligned,
  input  logic            i_riscv_em_load_misaligned,
  input  logic            i_riscv_em_store_misaligned,
  output logic            o_riscv_em_valid,
  output logic [XLEN-1:0] o_riscv_em_pc,
  output logic [XLEN-1:0] o_riscv_em_result,
  output logic [XLEN-1:0] o_riscv_em_dcache_addr,
  output logic [XLEN-1:0] o_riscv_em_csrwritedata,
  output logic [XLEN-1:0] o_riscv_em_dcache_wdata,
  output logic [7:0]      o_riscv_em_byte_en,
  output logic            o_riscv_em_memw,
  output logic            o_riscv_em_memr,
  output logic            o_riscv_em_regw,
  output logic [2:0]      o_riscv_em_memext,
  output logic [4:0]      o_riscv_em_rdaddr,
  output logic [2:0]      o_riscv_em_resultsrc,
  output logic            o_riscv_em_exc_valid,
  output logic [3:0]      o_riscv_em_exc_cause
);

  em_reg_t     em_q, em_d;
  logic        flush_pend_q, flush_pend_d;
  exc_t        exc_s;
  logic [63:0] wdata_s;
  logic [7:0]  byte_en_s;

  riscv_store_align u_store_align (
    .addr_i     (i_riscv_em_dcache_addr[2:0]),
    .storesrc_i (i_riscv_em_storesrc),
    .data_i     (i_riscv_em_store_data),
    .wdata_o    (wdata_s),
    .byte_en_o  (byte_en_s)
  );

  // Next stage contents: bubble on (pending) flush, else qualified inputs.
  always_comb begin
    exc_s = exc_encode(i_riscv_em_inst_misaligned, i_riscv_em_load_misaligned,
                       i_riscv_em_store_misaligned);
    em_d  = '0;
    if (i_riscv_em_flush || flush_pend_q) begin
      em_d = '0;
    end else begin
      em_d.valid        = i_riscv_em_valid;
      em_d.pc           = i_riscv_em_pc;
      em_d.result       = i_riscv_em_result;
      em_d.dcache_addr  = i_riscv_em_dcache_addr;
      em_d.csrwritedata = i_riscv_em_csrwritedata;
      em_d.wdata        = wdata_s;
      em_d.memext       = i_riscv_em_memext;
      em_d.rdaddr       = i_riscv_em_rdaddr;
      em_d.resultsrc    = i_riscv_em_resultsrc;
      if (i_riscv_em_valid && exc_s.valid) begin
        em_d.exc_valid = 1'b1;
        em_d.exc_cause = exc_s.cause;
      end else if (i_riscv_em_valid) begin
        em_d.memw = i_riscv_em_memw;
        em_d.memr = i_riscv_em_memr;
        em_d.regw = i_riscv_em_regw;
      end else begin
        em_d.memw = 1'b0;
      end
      em_d.byte_en = em_d.memw ? byte_en_s : 8'h00;
    end
  end

  // A flush seen during a stall is remembered until the first free edge.
  always_comb begin
    if (i_riscv_em_globstall) begin
      flush_pend_d = flush_pend_q | i_riscv_em_flush;
    end else begin
      flush_pend_d = 1'b0;
    end
  end

  // Pending-flush flag.
  always_ff @(posedge i_riscv_em_clk or posedge i_riscv_em_rst) begin
    if (i_riscv_em_rst) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end

  // Stage register, held while globally stalled.
  always_ff @(posedge i_riscv_em_clk or posedge i_riscv_em_rst) begin
    if (i_riscv_em_rst) begin
      em_q <= '0;
    end else if (!i_riscv_em_globstall) begin
      em_q <= em_d;
    end else begin
      em_q <= em_q;
    end
  end

  assign o_riscv_em_valid        = em_q.valid;
  assign o_riscv_em_pc           = em_q.pc;
  assign o_riscv_em_result       = em_q.result;
  assign o_riscv_em_dcache_addr  = em_q.dcache_addr;
  assign o_riscv_em_csrwritedata = em_q.csrwritedata;
  assign o_riscv_em_dcache_wdata = em_q.wdata;
  assign o_riscv_em_byte_en      = em_q.byte_en;
  assign o_riscv_em_memw         = em_q.memw;
  assign o_riscv_em_memr         = em_q.memr;
  assign o_riscv_em_regw         = em_q.regw;
  assign o_riscv_em_memext       = em_q.memext;
  assign o_riscv_em_rdaddr       = em_q.rdaddr;
  assign o_riscv_em_resultsrc    = em_q.resultsrc;
  assign o_riscv_em_exc_valid    = em_q.exc_valid;
  assign o_riscv_em_exc_cause    = em_q.exc_cause;

endmodule

// File: tb/tb_riscv_em_ppreg.sv
// Scoreboard bench for riscv_em_ppreg: a reference model predicts each capture,
// the prediction is queued, and it is compared one clock later.
module tb_riscv_em_ppreg;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc, result, addr, csr, wdata;
    logic [7:0]  be;
    logic        memw, memr, regw;
    logic [2:0]  memext;
    logic [4:0]  rd;
    logic [2:0]  rsrc;
    logic        exc_v;
    logic [3:0]  cause;
  } exp_t;

  logic clk = 1'b0;
  logic rst, stall, flush, valid, memw, memr, regw;
  logic inst_mis, load_mis, store_mis;
  logic [63:0] pc, result, addr, sdata, csr;
  logic [1:0]  storesrc;
  logic [2:0]  memext, rsrc;
  logic [4:0]  rd;

  logic        o_valid, o_memw, o_memr, o_regw, o_exc_v;
  logic [63:0] o_pc, o_result, o_addr, o_csr, o_wdata;
  logic [7:0]  o_be;
  logic [2:0]  o_memext, o_rsrc;
  logic [4:0]  o_rd;
  logic [3:0]  o_cause;

  exp_t sb[$];
  exp_t cur_m;
  bit   pend_m;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  riscv_em_ppreg #(.XLEN(64)) dut (
    .i_riscv_em_clk(clk), .i_riscv_em_rst(rst), .i_riscv_em_globstall(stall),
    .i_riscv_em_flush(flush), .i_riscv_em_valid(valid), .i_riscv_em_pc(pc),
    .i_riscv_em_result(result), .i_riscv_em_dcache_addr(addr),
    .i_riscv_em_store_data(sdata), .i_riscv_em_memw(memw), .i_riscv_em_memr(memr),
    .i_riscv_em_storesrc(storesrc), .i_riscv_em_memext(memext), .i_riscv_em_regw(regw),
    .i_riscv_em_rdaddr(rd), .i_riscv_em_resultsrc(rsrc), .i_riscv_em_csrwritedata(csr),
    .i_riscv_em_inst_misaligned(inst_mis), .i_riscv_em_load_misaligned(load_mis),
    .i_riscv_em_store_misaligned(store_mis),
    .o_riscv_em_valid(o_valid), .o_riscv_em_pc(o_pc), .o_riscv_em_result(o_result),
    .o_riscv_em_dcache_addr(o_addr), .o_riscv_em_csrwritedata(o_csr),
    .o_riscv_em_dcache_wdata(o_wdata), .o_riscv_em_byte_en(o_be),
    .o_riscv_em_memw(o_memw), .o_riscv_em_memr(o_memr), .o_riscv_em_regw(o_regw),
    .o_riscv_em_memext(o_memext), .o_riscv_em_rdaddr(o_rd),
    .o_riscv_em_resultsrc(o_rsrc), .o_riscv_em_exc_valid(o_exc_v),
    .o_riscv_em_exc_cause(o_cause)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_eq({tag, ".valid"},  64'(o_valid),  64'(e.valid));
    check_eq({tag, ".pc"},     o_pc,          e.pc);
    check_eq({tag, ".result"}, o_result,      e.result);
    check_eq({tag, ".addr"},   o_addr,        e.addr);
    check_eq({tag, ".csr"},    o_csr,         e.csr);
    check_eq({tag, ".wdata"},  o_wdata,       e.wdata);
    check_eq({tag, ".be"},     64'(o_be),     64'(e.be));
    check_eq({tag, ".memw"},   64'(o_memw),   64'(e.memw));
    check_eq({tag, ".memr"},   64'(o_memr),   64'(e.memr));
    check_eq({tag, ".regw"},   64'(o_regw),   64'(e.regw));
    check_eq({tag, ".memext"}, 64'(o_memext), 64'(e.memext));
    check_eq({tag, ".rd"},     64'(o_rd),     64'(e.rd));
    check_eq({tag, ".rsrc"},   64'(o_rsrc),   64'(e.rsrc));
    check_eq({tag, ".exc_v"},  64'(o_exc_v),  64'(e.exc_v));
    check_eq({tag, ".cause"},  64'(o_cause),  64'(e.cause));
  endtask

  // Reference capture: size n bytes, lanes at the n-aligned offset, data byte i%n in lane i.
  function automatic exp_t capture_inputs();
    exp_t e;
    int n, off;
    e = '0;
    e.valid = valid; e.pc = pc; e.result = result; e.addr = addr; e.csr = csr;
    e.memext = memext; e.rd = rd; e.rsrc = rsrc;
    n   = 1 << storesrc;
    off = int'(addr[2:0]) & ~(n - 1);
    for (int i = 0; i < 8; i++) e.wdata[i*8 +: 8] = sdata[(i % n)*8 +: 8];
    if (valid) begin
      e.exc_v = inst_mis | load_mis | store_mis;
      e.cause = inst_mis ? 4'd0 : load_mis ? 4'd4 : store_mis ? 4'd6 : 4'd0;
      if (!e.exc_v) begin
        e.memw = memw; e.memr = memr; e.regw = regw;
      end
    end
    if (e.memw) for (int i = off; i < off + n; i++) e.be[i] = 1'b1;
    return e;
  endfunction

  task automatic set_random();
    valid = 1'($urandom_range(0, 1));
    pc = {$urandom, $urandom}; result = {$urandom, $urandom};
    addr = {$urandom, $urandom}; sdata = {$urandom, $urandom}; csr = {$urandom, $urandom};
    memw = 1'($urandom_range(0, 1)); memr = 1'($urandom_range(0, 1));
    regw = 1'($urandom_range(0, 1));
    storesrc = 2'($urandom_range(0, 3)); memext = 3'($urandom_range(0, 7));
    rsrc = 3'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
    inst_mis = ($urandom_range(0, 7) == 0); load_mis = ($urandom_range(0, 7) == 0);
    store_mis = ($urandom_range(0, 7) == 0);
  endtask

  task automatic clear_flags();
    inst_mis = 1'b0; load_mis = 1'b0; store_mis = 1'b0;
  endtask

  // Predict the next edge, push it, let the edge happen, compare on the falling edge.
  task automatic step(input string tag);
    exp_t e;
    if (stall) begin
      pend_m = pend_m | flush;
    end else if (flush || pend_m) begin
      cur_m = '0; pend_m = 1'b0;
    end else begin
      cur_m = capture_inputs();
    end
    sb.push_back(cur_m);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_random();
    cur_m = '0; pend_m = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset", '0);
    rst = 1'b0;

    // Halfword store to offset 6.
    set_random(); clear_flags();
    valid = 1'b1; memw = 1'b1; addr = 64'h0000_0000_1000_0006; storesrc = 2'b01;
    sdata = 64'h0123_4567_89AB_BEEF;
    step("half");
    check_eq("half.be_c0", 64'(o_be), 64'h00000000000000C0);
    check_eq("half.wdata_k", o_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    check_eq("half.memw_k", 64'(o_memw), 64'd1);

    // Load misaligned.
    set_random(); clear_flags();
    valid = 1'b1; memr = 1'b1; regw = 1'b1; load_mis = 1'b1;
    step("ldmis");
    check_eq("ldmis.exc_k", 64'(o_exc_v), 64'd1);
    check_eq("ldmis.cause_k", 64'(o_cause), 64'd4);
    check_eq("ldmis.memr_k", 64'(o_memr), 64'd0);
    check_eq("ldmis.regw_k", 64'(o_regw), 64'd0);

    // Flush without stall.
    set_random(); clear_flags();
    valid = 1'b1; regw = 1'b1; result = 64'h1234; flush = 1'b1;
    step("flush");
    check_eq("flush.valid_k", 64'(o_valid), 64'd0);
    check_eq("flush.regw_k", 64'(o_regw), 64'd0);
    check_eq("flush.result_k", o_result, 64'd0);
    flush = 1'b0;

    // Deferred flush inside a three-edge stall.
    set_random(); clear_flags(); valid = 1'b1;
    step("pre_stall");
    set_random(); stall = 1'b1; flush = 1'b1;
    step("stall0");
    set_random(); flush = 1'b0;
    step("stall1");
    set_random();
    step("stall2");
    set_random(); clear_flags(); valid = 1'b1; stall = 1'b0;
    step("defer_bubble");
    check_eq("defer_bubble.valid_k", 64'(o_valid), 64'd0);
    set_random(); clear_flags(); valid = 1'b1;
    step("after_bubble");
    check_eq("after_bubble.valid_k", 64'(o_valid), 64'd1);

    // Exception priority with a store.
    set_random(); clear_flags();
    valid = 1'b1; memw = 1'b1; inst_mis = 1'b1; store_mis = 1'b1;
    step("prio");
    check_eq("prio.cause_k", 64'(o_cause), 64'd0);
    check_eq("prio.memw_k", 64'(o_memw), 64'd0);
    check_eq("prio.be_k", 64'(o_be), 64'd0);

    // Async reset mid-stall with a flush pending.
    set_random(); stall = 1'b1; flush = 1'b1;
    step("pre_arst");
    #2 rst = 1'b1;
    #1 check_outputs("arst", '0);
    cur_m = '0; pend_m = 1'b0; sb.delete();
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_random(); clear_flags(); valid = 1'b1;
    step("post_arst");
    check_eq("post_arst.valid_k", 64'(o_valid), 64'd1);

    // Back-to-back flushes.
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random(); valid = 1'b1;
      step("b2b_flush");
    end
    flush = 1'b0;

    // Random traffic with stalls and flushes.
    for (int i = 0; i < 300; i++) begin
      set_random();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
